// File: rtl/fb_rect_draw_engine.sv
// fb_rect_draw_engine
// Command-driven primitive drawer for the VGA frame buffer. It draws horizontal
// lines, vertical lines, filled rectangles and rectangle outlines, and writes one
// pixel per clock into the frame driver's write port.
//
// Optional feature macro: FB_DRAW_CLIP_EN. When it is defined, pixels outside
// FB_WIDTH x FB_HEIGHT are suppressed but still take their draw cycle.
//
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   cmd_valid / cmd_ready                 command handshake (ready only in IDLE)
//   cmd_mode                              00 HLINE, 01 VLINE, 10 FILL, 11 OUTLINE
//   cmd_x0, cmd_y0, cmd_w, cmd_h          top-left corner and extent
//   cmd_color                             pixel data
//   busy, done                            not-IDLE flag, one-cycle completion pulse
//   the_vga_draw_frame_write_mem_address  write address
//   the_vga_draw_frame_write_mem_data     write data
//   the_vga_draw_frame_write_a_pixel      write strobe
module fb_rect_draw_engine #(
  parameter int unsigned FB_WIDTH  = 160,
  parameter int unsigned FB_HEIGHT = 120,
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned COLOR_W   = 24,
  parameter int unsigned COORD_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_mode,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_w,
  input  logic [COORD_W-1:0] cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  the_vga_draw_frame_write_mem_address,
  output logic [COLOR_W-1:0] the_vga_draw_frame_write_mem_data,
  output logic               the_vga_draw_frame_write_a_pixel
);

  // One extra bit so that an extent of 2**COORD_W-1 cannot overflow.
  localparam int unsigned CNT_W = COORD_W + 1;
  // Wide enough to hold the sum of a coordinate and a counter.
  localparam int unsigned SUM_W = COORD_W + 2;

  // The whole frame must be addressable.
  if (64'(FB_WIDTH) * 64'(FB_HEIGHT) > (64'd1 << ADDR_W)) begin : g_cfg_chk
    $error("fb_rect_draw_engine: frame does not fit in ADDR_W address bits");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     c_q, r_q, w_q, h_q;
  logic [ADDR_W-1:0]    base_q;
  logic [COORD_W-1:0]   x0_q, y0_q;
  logic [COLOR_W-1:0]   color_q;
  logic                 outline_q;
  logic                 ready_q, busy_q, done_q, we_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [COLOR_W-1:0]   data_q;

  logic [CNT_W-1:0]     c_d, r_d;
  logic [ADDR_W-1:0]    base_d, setup_base;
  logic                 zero_ext, last_px, interior, clipped, we_d;

  // Next pixel to present: pixel 0 from SETUP, otherwise the raster successor.
  always_comb begin
    setup_base = ADDR_W'(y0_q) * ADDR_W'(FB_WIDTH) + ADDR_W'(x0_q);
    zero_ext   = (w_q == '0) || (h_q == '0);
    last_px    = (c_q == w_q - CNT_W'(1)) && (r_q == h_q - CNT_W'(1));
    c_d        = '0;
    r_d        = '0;
    base_d     = setup_base;
    if (state_q == S_DRAW) begin
      if (c_q == w_q - CNT_W'(1)) begin
        c_d    = '0;
        r_d    = r_q + CNT_W'(1);
        base_d = base_q + ADDR_W'(FB_WIDTH);
      end else begin
        c_d    = c_q + CNT_W'(1);
        r_d    = r_q;
        base_d = base_q;
      end
    end
    // Strictly inside the border: not the first/last column and not the first/last row.
    interior = outline_q && (c_d != '0) && (c_d != w_q - CNT_W'(1)) &&
               (r_d != '0) && (r_d != h_q - CNT_W'(1));
`ifdef FB_DRAW_CLIP_EN
    clipped  = (SUM_W'(x0_q) + SUM_W'(c_d) >= SUM_W'(FB_WIDTH)) ||
               (SUM_W'(y0_q) + SUM_W'(r_d) >= SUM_W'(FB_HEIGHT));
`else
    clipped  = 1'b0;
`endif
    we_d     = !interior && !clipped;
  end

  // Control FSM with registered write-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      c_q       <= '0;
      r_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      base_q    <= '0;
      x0_q      <= '0;
      y0_q      <= '0;
      color_q   <= '0;
      outline_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            x0_q      <= cmd_x0;
            y0_q      <= cmd_y0;
            color_q   <= cmd_color;
            outline_q <= (cmd_mode == 2'b11);
            // A VLINE is one column wide and an HLINE is one row tall.
            w_q       <= (cmd_mode == 2'b01) ? CNT_W'(1) : CNT_W'(cmd_w);
            h_q       <= (cmd_mode == 2'b00) ? CNT_W'(1) : CNT_W'(cmd_h);
            state_q   <= S_SETUP;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        S_SETUP, S_DRAW: begin
          if ((state_q == S_SETUP && zero_ext) || (state_q == S_DRAW && last_px)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            we_q    <= 1'b0;
          end else begin
            state_q <= S_DRAW;
            c_q     <= c_d;
            r_q     <= r_d;
            base_q  <= base_d;
            addr_q  <= base_d + ADDR_W'(c_d);
            we_q    <= we_d;
            if (we_d) begin
              data_q <= color_q;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          we_q    <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready                            = ready_q;
  assign busy                                 = busy_q;
  assign done                                 = done_q;
  assign the_vga_draw_frame_write_mem_address = addr_q;
  assign the_vga_draw_frame_write_mem_data    = data_q;
  assign the_vga_draw_frame_write_a_pixel     = we_q;

endmodule

// File: tb/tb_fb_rect_draw_engine.sv
// tb_fb_rect_draw_engine
// Directed bench for fb_rect_draw_engine. Each command is issued at a falling
// edge. The acceptance edge ends cycle 0. The outputs are then sampled on every
// falling edge (cycle 1, 2, ...), and every sample is compared with
// hand-computed pixel streams and done/ready/busy timing.
module tb_fb_rect_draw_engine;

  localparam int unsigned ADDR_W  = 15;
  localparam int unsigned COLOR_W = 24;
  localparam int unsigned COORD_W = 8;
  localparam int          MAXC    = 128;

  logic               clk;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_mode;
  logic [COORD_W-1:0] cmd_x0, cmd_y0, cmd_w, cmd_h;
  logic [COLOR_W-1:0] cmd_color;
  logic               busy, done;
  logic [ADDR_W-1:0]  wr_addr;
  logic [COLOR_W-1:0] wr_data;
  logic               wr_px;

  fb_rect_draw_engine #(
    .FB_WIDTH (160),
    .FB_HEIGHT(120),
    .ADDR_W   (ADDR_W),
    .COLOR_W  (COLOR_W),
    .COORD_W  (COORD_W)
  ) dut (
    .clk                                 (clk),
    .rst                                 (rst),
    .cmd_valid                           (cmd_valid),
    .cmd_ready                           (cmd_ready),
    .cmd_mode                            (cmd_mode),
    .cmd_x0                              (cmd_x0),
    .cmd_y0                              (cmd_y0),
    .cmd_w                               (cmd_w),
    .cmd_h                               (cmd_h),
    .cmd_color                           (cmd_color),
    .busy                                (busy),
    .done                                (done),
    .the_vga_draw_frame_write_mem_address(wr_addr),
    .the_vga_draw_frame_write_mem_data   (wr_data),
    .the_vga_draw_frame_write_a_pixel    (wr_px)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic               strb_a [MAXC];
  logic [ADDR_W-1:0]  addr_a [MAXC];
  logic [COLOR_W-1:0] data_a [MAXC];
  logic               done_a [MAXC];
  logic               rdy_a  [MAXC];
  logic               busy_a [MAXC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command from a falling edge and record cycles 1..ncyc.
  // rst is raised for one edge at the end of cycle rst_cyc (-1 means no reset).
  task automatic run_cmd(input logic [1:0] mode, input int x0, input int y0,
                         input int w, input int h, input logic [COLOR_W-1:0] color,
                         input int ncyc, input int rst_cyc);
    chk("accept_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_x0    = COORD_W'(x0);
    cmd_y0    = COORD_W'(y0);
    cmd_w     = COORD_W'(w);
    cmd_h     = COORD_W'(h);
    cmd_color = color;
    @(posedge clk);
    #1;
    // Fields change after acceptance and must have no effect.
    cmd_valid = 1'b0;
    cmd_x0    = 8'h55;
    cmd_y0    = 8'h33;
    cmd_w     = 8'hAA;
    cmd_h     = 8'h77;
    cmd_color = 24'hDEAD01;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      strb_a[cyc] = wr_px;
      addr_a[cyc] = wr_addr;
      data_a[cyc] = wr_data;
      done_a[cyc] = done;
      rdy_a[cyc]  = cmd_ready;
      busy_a[cyc] = busy;
      rst = (cyc == rst_cyc);
      // Extra command attempts while the engine is busy are ignored.
      cmd_valid = (cyc == 1);
    end
    cmd_valid = 1'b0;
  endtask

  // Compare recorded cycles against an expected pixel stream of n draw cycles.
  task automatic chk_stream(input string tag, input int n, input int ea[$], input bit es[$],
                            input logic [COLOR_W-1:0] color, input int done_cyc, input int ncyc);
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      bit exp_s;
      exp_s = (cyc >= 2 && cyc < 2 + n) ? es[cyc-2] : 1'b0;
      chk($sformatf("%s_strb[%0d]", tag, cyc), 32'(strb_a[cyc]), 32'(exp_s));
      if (exp_s) begin
        chk($sformatf("%s_addr[%0d]", tag, cyc), 32'(addr_a[cyc]), 32'(ea[cyc-2]));
        chk($sformatf("%s_data[%0d]", tag, cyc), 32'(data_a[cyc]), 32'(color));
      end
      chk($sformatf("%s_done[%0d]", tag, cyc), 32'(done_a[cyc]), 32'(cyc == done_cyc));
      chk($sformatf("%s_rdy[%0d]", tag, cyc), 32'(rdy_a[cyc]), 32'(cyc > done_cyc));
      chk($sformatf("%s_busy[%0d]", tag, cyc), 32'(busy_a[cyc]), 32'(cyc <= done_cyc));
    end
  endtask

  initial begin
    int ea[$];
    bit es[$];

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_mode  = 2'b00;
    cmd_x0    = '0;
    cmd_y0    = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    cmd_color = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_addr",  32'(wr_addr),   32'd0);
    chk("rst_data",  32'(wr_data),   32'd0);
    chk("rst_strb",  32'(wr_px),     32'd0);
    rst = 1'b0;
    @(negedge clk);

    // HLINE at (11,0), 60 wide. cmd_h is ignored.
    ea = {}; es = {};
    for (int k = 0; k < 60; k++) begin ea.push_back(11 + k); es.push_back(1'b1); end
    run_cmd(2'b00, 11, 0, 60, 5, 24'h0000FF, 64, -1);
    chk_stream("hline", 60, ea, es, 24'h0000FF, 62, 64);

    // VLINE at (12,0), 100 tall. cmd_w = 37 is ignored.
    ea = {}; es = {};
    for (int k = 0; k < 100; k++) begin ea.push_back(12 + 160 * k); es.push_back(1'b1); end
    run_cmd(2'b01, 12, 0, 37, 100, 24'h00FF00, 104, -1);
    chk_stream("vline", 100, ea, es, 24'h00FF00, 102, 104);

    // OUTLINE 4x3 at (0,0). Interior pixels 161 and 162 are not written.
    ea = {}; es = {};
    for (int k = 0; k < 12; k++) begin
      ea.push_back((k / 4) * 160 + (k % 4));
      es.push_back(!(k == 5 || k == 6));
    end
    run_cmd(2'b11, 0, 0, 4, 3, 24'hFF0000, 15, -1);
    chk_stream("outline", 12, ea, es, 24'hFF0000, 14, 15);

    // FILL 3x2 at (158,119), in the bottom-right corner.
    ea = {}; es = {};
    for (int k = 0; k < 6; k++) begin
      ea.push_back(19198 + (k / 3) * 160 + (k % 3));
`ifdef FB_DRAW_CLIP_EN
      es.push_back(k < 2);
`else
      es.push_back(1'b1);
`endif
    end
    run_cmd(2'b10, 158, 119, 3, 2, 24'h123456, 9, -1);
    chk_stream("clipfill", 6, ea, es, 24'h123456, 8, 9);

    // A zero-width FILL is followed directly by an HLINE issued in cycle 3.
    ea = {}; es = {};
    run_cmd(2'b10, 20, 20, 0, 5, 24'hABCDEF, 3, -1);
    chk_stream("zero", 0, ea, es, 24'hABCDEF, 2, 3);
    ea = {325, 326}; es = {1'b1, 1'b1};
    run_cmd(2'b00, 5, 2, 2, 9, 24'h0F0F0F, 6, -1);
    chk_stream("b2b", 2, ea, es, 24'h0F0F0F, 4, 6);

    // HLINE at (0,1) aborted by reset at the end of cycle 10.
    run_cmd(2'b00, 0, 1, 60, 1, 24'h777777, 30, 10);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      chk($sformatf("abort_strb[%0d]", cyc), 32'(strb_a[cyc]), 32'(cyc >= 2 && cyc <= 10));
      if (cyc >= 2 && cyc <= 10) begin
        chk($sformatf("abort_addr[%0d]", cyc), 32'(addr_a[cyc]), 32'(160 + cyc - 2));
      end
      chk($sformatf("abort_done[%0d]", cyc), 32'(done_a[cyc]), 32'd0);
      chk($sformatf("abort_rdy[%0d]", cyc), 32'(rdy_a[cyc]), 32'(cyc >= 11));
      chk($sformatf("abort_busy[%0d]", cyc), 32'(busy_a[cyc]), 32'(cyc <= 10));
    end
    chk("abort_addr_rst", 32'(addr_a[11]), 32'd0);
    chk("abort_data_rst", 32'(data_a[11]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
